// File: rtl/fpu_pkg.sv
// Shared FPU definitions: itof arbiter state encoding, canonical quiet NaN
// and default requester count.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } itof_arb_state_t;

    localparam logic [31:0] FPU_QNAN      = 32'h7FC0_0000;
    localparam int          ITOF_ARB_NREQ = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first asserted req at or above ptr,
// wrapping modulo N. Returns a one-hot grant and its binary index.
module rr_pick #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    logic found;
    int   c;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = PW'(c);
            end
        end
    end

endmodule

// File: rtl/itof_arb.sv
// Round-robin scheduler sharing one itof converter among NREQ requesters,
// one conversion in flight. Define ITOF_ARB_TIMEOUT_EN for the converter watchdog.
module itof_arb
    import fpu_pkg::*;
#(
    parameter int NREQ    = ITOF_ARB_NREQ,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_x,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    output logic [31:0]          resp_y,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [31:0]          cvt_x,
    output logic                 cvt_ready,
    input  logic                 cvt_valid,
    input  logic [31:0]          cvt_y,
    output logic                 err
);

    localparam int PW = $clog2(NREQ);

    itof_arb_state_t state_q, state_d;
    logic [PW-1:0]   ptr_q, own_q, pick_idx;
    logic [NREQ-1:0] pick_gnt;
    logic [31:0]     op_q, res_q, pick_x;
    logic            accept, cvt_done, wd_fire, release_own;

    rr_pick #(.N(NREQ)) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_comb begin
        pick_x = '0;
        for (int i = 0; i < NREQ; i++)
            if (pick_gnt[i]) pick_x |= req_x[32*i +: 32];
    end

    assign accept      = (state_q == IDLE) && (|req_valid);
    assign cvt_done    = (state_q == BUSY) && cvt_valid;
    assign release_own = (state_q == RESP) && resp_ready[own_q];

`ifdef ITOF_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd_q;
    logic          err_q;

    // Fires on the TIMEOUT-th consecutive BUSY cycle without a converter result.
    assign wd_fire = (state_q == BUSY) && !cvt_valid && (wd_q == WW'(TIMEOUT - 1));
    assign err     = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept)
                wd_q <= '0;
            else if ((state_q == BUSY) && !cvt_valid)
                wd_q <= wd_q + 1'b1;
            if (wd_fire)
                err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign wd_fire        = 1'b0;
    assign err            = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        resp_valid = '0;
        cvt_ready  = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = pick_gnt;
                if (|req_valid) state_d = BUSY;
            end
            BUSY: begin
                cvt_ready = 1'b1;
                if (cvt_valid || wd_fire) state_d = RESP;
            end
            RESP: begin
                resp_valid[own_q] = 1'b1;
                if (resp_ready[own_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= pick_x;
                own_q <= pick_idx;
            end
            if (cvt_done)
                res_q <= cvt_y;
            else if (wd_fire)
                res_q <= FPU_QNAN;
            // Priority rotates past the requester just served.
            if (release_own)
                ptr_q <= (own_q == PW'(NREQ - 1)) ? '0 : own_q + 1'b1;
        end
    end

    assign cvt_x  = op_q;
    assign resp_y = res_q;

endmodule

// File: tb/tb_itof_arb.sv
// Directed bench for itof_arb with a combinational itof stand-in whose
// valid can be gated to create converter stalls.
`timescale 1ns/1ps
module tb_itof_arb;

    localparam int NREQ = 4;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [32*NREQ-1:0]   req_x = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      resp_valid;
    logic [31:0]          resp_y;
    logic [NREQ-1:0]      resp_ready = '1;
    logic [31:0]          cvt_x;
    logic                 cvt_ready;
    logic                 cvt_valid;
    logic [31:0]          cvt_y;
    logic                 err;
    logic                 cvt_en = 1'b1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] ops  [4];
    logic [31:0] exps [4];

    itof_arb #(.NREQ(NREQ), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_y     (resp_y),
        .resp_ready (resp_ready),
        .cvt_x      (cvt_x),
        .cvt_ready  (cvt_ready),
        .cvt_valid  (cvt_valid),
        .cvt_y      (cvt_y),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Round-to-nearest-even int32 -> binary32, standing in for the itof block.
    function automatic logic [31:0] itof_ref(input logic [31:0] x);
        logic [31:0] m, rem, half;
        logic [24:0] man;
        logic [7:0]  e;
        int          p, sh;
        if (x == 32'd0) return 32'd0;
        m = x[31] ? (~x + 32'd1) : x;
        p = 0;
        for (int b = 0; b < 32; b++) if (m[b]) p = b;
        e = 8'(127 + p);
        if (p <= 23) begin
            man = 25'(m << (23 - p));
        end else begin
            sh   = p - 23;
            man  = 25'(m >> sh);
            rem  = m & ((32'd1 << sh) - 32'd1);
            half = 32'd1 << (sh - 1);
            if (rem > half || (rem == half && man[0])) man = man + 25'd1;
            if (man[24]) begin
                man = man >> 1;
                e   = e + 8'd1;
            end
        end
        return {x[31], e, man[22:0]};
    endfunction

    assign cvt_valid = cvt_ready & cvt_en;
    assign cvt_y     = itof_ref(cvt_x);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, got, exp);
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    // One uncontended transaction with resp_ready high; starts and ends just after a posedge.
    task automatic xact(input int i, input logic [31:0] x, input logic [31:0] y);
        req_valid          = '0;
        req_valid[i]       = 1'b1;
        req_x[32*i +: 32]  = x;
        smp;
        chk("gnt", 32'(req_ready), 32'(1) << i);
        nxt;
        req_valid = '0;
        smp;
        chk("busy_cvt_rdy", 32'(cvt_ready), 32'd1);
        chk("busy_cvt_x", cvt_x, x);
        chk("busy_req_rdy", 32'(req_ready), 32'd0);
        nxt;
        smp;
        chk("rsp_valid", 32'(resp_valid), 32'(1) << i);
        chk("rsp_y", resp_y, y);
        nxt;
        smp;
        chk("idle_rsp_valid", 32'(resp_valid), 32'd0);
        chk("idle_cvt_rdy", 32'(cvt_ready), 32'd0);
        nxt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, at %0t", $time);
        $fatal(1);
    end

    initial begin
        ops[0] = 32'd3;          exps[0] = 32'h4040_0000;
        ops[1] = 32'hFFFF_FFFF;  exps[1] = 32'hBF80_0000;
        ops[2] = 32'd256;        exps[2] = 32'h4380_0000;
        ops[3] = 32'hFFFF_FF9C;  exps[3] = 32'hC2C8_0000;

        // Reset state
        smp;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_cvt_ready", 32'(cvt_ready), 32'd0);
        chk("rst_cvt_x", cvt_x, 32'd0);
        chk("rst_resp_y", resp_y, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        nxt;
        rstn = 1'b1;
        smp;
        chk("idle_no_req", 32'(req_ready), 32'd0);
        nxt;

        // Single requests, conversion corner values, pointer wrap from 3 to 0
        xact(0, 32'd1,         32'h3F80_0000);
        xact(2, 32'hFFFF_FFFE, 32'hC000_0000);
        xact(2, 32'd0,         32'h0000_0000);
        xact(2, 32'h7FFF_FFFF, 32'h4F00_0000);
        xact(3, 32'hFFFF_FF9C, 32'hC2C8_0000);

        // Fairness: all requesters continuously valid, expect 0,1,2,3,0
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) req_x[32*i +: 32] = ops[i];
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % 4;
            smp;
            chk("fair_gnt", 32'(req_ready), 32'(1) << g);
            nxt;
            smp;
            chk("fair_cvt_x", cvt_x, ops[g]);
            chk("fair_busy_rdy", 32'(req_ready), 32'd0);
            nxt;
            smp;
            chk("fair_rsp_valid", 32'(resp_valid), 32'(1) << g);
            chk("fair_rsp_y", resp_y, exps[g]);
            nxt;
        end
        req_valid = '0;

        // Back-pressure on requester 1; requester 0 waits throughout
        resp_ready        = 4'b1101;
        req_valid         = 4'b0011;
        req_x[0 +: 32]    = 32'd7;
        req_x[32 +: 32]   = 32'd5;
        smp;
        chk("bp_gnt", 32'(req_ready), 32'h2);
        nxt;
        req_valid = 4'b0001;
        smp;
        chk("bp_busy", 32'(cvt_ready), 32'd1);
        for (int c = 0; c < 5; c++) begin
            nxt;
            smp;
            chk("bp_hold_valid", 32'(resp_valid), 32'h2);
            chk("bp_hold_y", resp_y, 32'h40A0_0000);
            chk("bp_hold_req_rdy", 32'(req_ready), 32'd0);
        end
        nxt;
        resp_ready = '1;
        smp;
        chk("bp_release_valid", 32'(resp_valid), 32'h2);
        nxt;
        smp;
        chk("bp_idle_gnt", 32'(req_ready), 32'h1);
        nxt;
        req_valid = '0;
        smp;
        chk("bp_next_cvt_x", cvt_x, 32'd7);
        nxt;
        smp;
        chk("bp_next_valid", 32'(resp_valid), 32'h1);
        chk("bp_next_y", resp_y, 32'h40E0_0000);
        nxt;

        // Reset while BUSY
        req_valid        = 4'b0100;
        req_x[64 +: 32]  = 32'd9;
        smp;
        chk("rm_gnt", 32'(req_ready), 32'h4);
        nxt;
        req_valid = '0;
        smp;
        chk("rm_busy", 32'(cvt_ready), 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk("rm_req_ready", 32'(req_ready), 32'd0);
        chk("rm_resp_valid", 32'(resp_valid), 32'd0);
        chk("rm_cvt_ready", 32'(cvt_ready), 32'd0);
        chk("rm_cvt_x", cvt_x, 32'd0);
        chk("rm_resp_y", resp_y, 32'd0);
        chk("rm_err", 32'(err), 32'd0);
        nxt;
        nxt;
        rstn = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) req_x[32*i +: 32] = ops[i];
        smp;
        chk("rm_post_gnt", 32'(req_ready), 32'h1);
        nxt;
        req_valid = '0;
        smp;
        chk("rm_post_cvt_x", cvt_x, ops[0]);
        nxt;
        smp;
        chk("rm_post_valid", 32'(resp_valid), 32'h1);
        chk("rm_post_y", resp_y, exps[0]);
        nxt;

        // Converter stall on requester 3
        cvt_en           = 1'b0;
        req_valid        = 4'b1000;
        req_x[96 +: 32]  = 32'd1;
        smp;
        chk("st_gnt", 32'(req_ready), 32'h8);
        nxt;
        req_valid = '0;
`ifdef ITOF_ARB_TIMEOUT_EN
        for (int c = 0; c < 16; c++) begin
            smp;
            chk("wd_busy", 32'(cvt_ready), 32'd1);
            chk("wd_err_low", 32'(err), 32'd0);
            nxt;
        end
        smp;
        chk("wd_rsp_valid", 32'(resp_valid), 32'h8);
        chk("wd_rsp_y", resp_y, 32'h7FC0_0000);
        chk("wd_err", 32'(err), 32'd1);
        nxt;
        smp;
        chk("wd_idle", 32'(resp_valid), 32'd0);
        chk("wd_err_sticky", 32'(err), 32'd1);
        cvt_en = 1'b1;
        nxt;
`else
        for (int c = 0; c < 20; c++) begin
            smp;
            chk("st_busy", 32'(cvt_ready), 32'd1);
            chk("st_no_rsp", 32'(resp_valid), 32'd0);
            nxt;
        end
        cvt_en = 1'b1;
        smp;
        chk("st_err", 32'(err), 32'd0);
        nxt;
        smp;
        chk("st_rsp_valid", 32'(resp_valid), 32'h8);
        chk("st_rsp_y", resp_y, 32'h3F80_0000);
        nxt;
        smp;
        chk("st_idle", 32'(resp_valid), 32'd0);
        chk("st_err_idle", 32'(err), 32'd0);
        nxt;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/itof_arb.md
# itof_arb

Round-robin scheduler that shares one integer-to-float converter (`itof`) among `NREQ` requesters. Each requester issues a signed 32-bit integer over a valid/ready request channel and receives the IEEE-754 single result over its own valid/ready response channel. The block holds one conversion in flight: it latches the operand, drives the converter's `ready`/`x`, captures `y` on converter `valid`, and holds the result until the owning requester accepts it. It sits between the core's FPU issue ports and the single `itof` instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 16: converter watchdog limit in cycles. Used only when `ITOF_ARB_TIMEOUT_EN` is defined.
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `req_valid` in NREQ: requester i has an operand.
- `req_x` in NREQ×32: operands, packed; requester i uses `[32*i+31:32*i]`.
- `req_ready` out NREQ: one-hot grant. The operand is accepted on `req_valid[i] & req_ready[i]`.
- `resp_valid` out NREQ: one-hot. The result for requester i is pending.
- `resp_y` out 32: result, shared by all requesters. Qualify with `resp_valid[i]`.
- `resp_ready` in NREQ: requester i accepts the result.
- `cvt_x` out 32: operand to the converter.
- `cvt_ready` out 1: converter start/hold strobe.
- `cvt_valid` in 1: the converter result is valid. May rise in the same cycle as `cvt_ready`.
- `cvt_y` in 32: converter result.
- `err` out 1: sticky watchdog flag. Tied to 0 without the macro.

## Operation
- States:
  - IDLE: no transaction.
  - BUSY: operand issued; waiting for `cvt_valid`.
  - RESP: result held for the owning requester.
- IDLE:
  - If any `req_valid` is high, pick the first asserted index starting at `ptr`, searching upward and wrapping modulo `NREQ`.
  - Assert `req_ready[g]` combinationally in that cycle.
  - On the same edge: latch `req_x[g]` into `op_q`, latch `g` into `own_q`, go to BUSY.
  - If no `req_valid` is high, `req_ready` = 0 and the state stays IDLE.
- BUSY:
  - `cvt_ready` = 1, `cvt_x` = `op_q`. Both are held steady until `cvt_valid` is seen.
  - On `cvt_valid`: latch `cvt_y` into `res_q` and go to RESP.
- RESP:
  - `resp_valid[own_q]` = 1, `resp_y` = `res_q`.
  - On `resp_ready[own_q]`: set `ptr` to (`own_q`+1) mod `NREQ` and go to IDLE.
  - `resp_ready` bits of other requesters are ignored.
- Outside IDLE, `req_ready` = 0. No request is accepted while a transaction is in flight.
- `cvt_x` = `op_q` in every state; `cvt_ready` is high only in BUSY.
- `ptr` width is $clog2(NREQ). Wrap: `own_q` = `NREQ`-1 gives `ptr` = 0.
- A requester dropping `req_valid` before it is granted is legal. It simply loses arbitration.
- Reset, including mid-transaction:
  - state = IDLE, `ptr` = 0, `op_q` = 0, `res_q` = 0, `own_q` = 0, `err` = 0.
  - Consequently `req_ready` = 0, `resp_valid` = 0, `cvt_ready` = 0, `cvt_x` = 0, `resp_y` = 0.
  - The in-flight transaction is discarded; requesters must reissue.

## Timing
- Grant happens in the cycle where IDLE coincides with `req_valid`. This is cycle 0.
- BUSY starts at cycle 1. With the combinational `itof` (`valid` = `ready`), `cvt_valid` is seen in cycle 1.
- `resp_valid` first rises at cycle 2.
- If `resp_ready` is high in cycle 2, the block is back in IDLE at cycle 3.
- Peak throughput: one conversion per 3 cycles.
- Each stall cycle on `cvt_valid` or `resp_ready` adds one cycle.
- Fairness: with all requesters continuously valid, grant order is 0,1,…,NREQ-1,0. Maximum wait is (NREQ-1) transactions.

## Configuration
- `ITOF_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle while `cvt_valid` is low.
  - When it reaches `TIMEOUT` with no `cvt_valid`: load `res_q` = 32'h7FC00000 (qNaN), set `err` = 1, go to RESP.
  - `err` stays at 1 until reset.
- `ITOF_ARB_TIMEOUT_EN` undefined:
  - No counter; BUSY waits indefinitely.
  - `err` is constant 0.

## Structure
- The shared package `fpu_pkg` holds:
  - the state enum `itof_arb_state_t` (IDLE, BUSY, RESP);
  - the constant `FPU_QNAN` = 32'h7FC00000;
  - the default `ITOF_ARB_NREQ` = 4.
- One sub-module, `rr_pick`. It is combinational:
  - parameter `N`;
  - inputs: `req[N]`, `ptr`;
  - outputs: one-hot `gnt[N]` and binary `idx`.
- The FSM, registers and watchdog live in `itof_arb`.

## Test plan
- Single request: requester 0 sends 1; `resp_ready` is tied high → `resp_valid[0]` at cycle 2, `resp_y` = 32'h3F800000, back in IDLE at cycle 3.
- Negative and zero: requester 2 sends 32'hFFFFFFFE → 32'hC0000000. Then 0 → 32'h00000000. Then 32'h7FFFFFFF → 32'h4F000000.
- Fairness: all four requesters continuously valid with distinct operands → grants in order 0,1,2,3,0. Each result routed only to its owner.
- Back-pressure: `resp_ready[1]` held low for 5 cycles → `resp_valid[1]` and `resp_y` stable, `req_ready` = 0 throughout. Release → IDLE the next cycle.
- Reset mid-operation: deassert `rstn` while in BUSY → all outputs 0 immediately. After release, a new request completes normally with `ptr` = 0.
- Watchdog (macro on, `TIMEOUT` = 16): hold `cvt_valid` low → after 16 BUSY cycles `resp_y` = 32'h7FC00000 and `err` = 1. `err` remains 1 after the response is accepted.
